// File: rtl/apb_slave_pkg.sv
// Shared types, limits and helpers for the APB3 scratch-memory completer.
// Used by apb_slave_regmem and apb_slave_mem.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_slv_state_e;

    localparam int MAX_WAIT       = 5;
    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_CALC_W    = 64;

    // 64-bit arithmetic keeps the window top from wrapping for windows near the top of the map.
    function automatic logic addr_err(input logic [ADDR_CALC_W-1:0] paddr,
                                      input logic [ADDR_CALC_W-1:0] base,
                                      input logic [ADDR_CALC_W-1:0] depth);
        logic [ADDR_CALC_W-1:0] top;
        top = base + (depth << 2);
        return (paddr[1:0] != 2'b00) || (paddr < base) || (paddr >= top);
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_slave_regmem.sv
// Word-addressed storage: synchronous clear on rst, byte-enable write port,
// combinational read port.
module apb_slave_regmem
    import apb_slave_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] wr_word_d;

    // Merge enabled byte lanes into the word being written.
    always_comb begin
        wr_word_d = byte_merge(mem_q[waddr], wdata, be);
    end

    // Storage array; reset wins over any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (we) begin
            mem_q[waddr] <= wr_word_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by apb_slave_regmem, with programmable wait states.
// Define APB_SLAVE_PSTRB_EN to add the APB4 pstrb byte-strobe port.
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
`ifdef APB_SLAVE_PSTRB_EN
    input  logic [3:0]        pstrb,
`endif
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
        $error("apb_slave_mem: WAIT_CYCLES must be in 0..5");
    end
    if (DATA_W != 32) begin : g_bad_data_w
        $error("apb_slave_mem: DATA_W must be 32");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("apb_slave_mem: DEPTH must be a power of 2, at least 2");
    end
    if (ADDR_W < IDX_W + 2 || ADDR_W > ADDR_CALC_W) begin : g_bad_addr_w
        $error("apb_slave_mem: ADDR_W out of range");
    end
    if (BASE_ADDR[IDX_W+1:0] != '0) begin : g_bad_base
        $error("apb_slave_mem: BASE_ADDR must be aligned to DEPTH*4");
    end

    apb_slv_state_e    state_q,   state_d;
    logic [2:0]        cnt_q,     cnt_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic              write_q,   write_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic              err_q,     err_d;
    logic [3:0]        strb_q,    strb_d;
    logic              pready_q,  pready_d;
    logic              pslverr_q, pslverr_d;
    logic [31:0]       prdata_q,  prdata_d;

    logic              setup_s;
    logic              setup_err_s;
    logic              strb_err_s;
    logic [3:0]        strb_in_s;
    logic [IDX_W-1:0]  setup_idx_s;
    logic [IDX_W-1:0]  mem_raddr_s;
    logic [31:0]       mem_rdata_s;
    logic              mem_we_s;

`ifdef APB_SLAVE_PSTRB_EN
    assign strb_in_s  = pstrb;
    assign strb_err_s = !pwrite && (pstrb != 4'b0000);
`else
    assign strb_in_s  = 4'b1111;
    assign strb_err_s = 1'b0;
`endif

    assign setup_s     = psel && !penable;
    assign setup_err_s = addr_err(ADDR_CALC_W'(paddr), ADDR_CALC_W'(BASE_ADDR),
                                  ADDR_CALC_W'(DEPTH)) || strb_err_s;
    assign setup_idx_s = paddr[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];
    // With zero wait states the read happens at the setup edge, before idx_q is loaded.
    assign mem_raddr_s = (state_q == IDLE) ? setup_idx_s : idx_q;

    apb_slave_regmem #(
        .DEPTH (DEPTH)
    ) u_regmem (
        .clk   (pclk),
        .rst   (rst),
        .we    (mem_we_s),
        .be    (strb_q),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (mem_raddr_s),
        .rdata (mem_rdata_s)
    );

    // Next-state, transfer capture and response generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        strb_d    = strb_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = 32'h0000_0000;
        mem_we_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (setup_s) begin
                    idx_d   = setup_idx_s;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    err_d   = setup_err_s;
                    strb_d  = strb_in_s;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = READY;
                        pready_d  = 1'b1;
                        pslverr_d = setup_err_s;
                        prdata_d  = (setup_err_s || pwrite) ? 32'h0000_0000 : mem_rdata_s;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == 3'd1) begin
                    state_d   = READY;
                    cnt_d     = 3'd0;
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    prdata_d  = (err_q || write_q) ? 32'h0000_0000 : mem_rdata_s;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            READY: begin
                state_d  = IDLE;
                mem_we_s = write_q && !err_q;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and response registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= 32'h0000_0000;
            err_q     <= 1'b0;
            strb_q    <= 4'b0000;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_apb_slave_mem;

    logic        pclk;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic        psel0, penable0, pwrite0;
    logic [31:0] paddr0, pwdata0, prdata0;
    logic        pready0, pslverr0;
`ifdef APB_SLAVE_PSTRB_EN
    logic [3:0]  pstrb, pstrb0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    apb_slave_mem dut (
        .pclk(pclk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
`ifdef APB_SLAVE_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_slave_mem #(.WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .rst(rst), .psel(psel0), .penable(penable0), .pwrite(pwrite0),
        .paddr(paddr0), .pwdata(pwdata0),
`ifdef APB_SLAVE_PSTRB_EN
        .pstrb(pstrb0),
`endif
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        psel = 1'b0; penable = 1'b0; psel0 = 1'b0; penable0 = 1'b0;
    endtask

    // One transfer; returns read data, error and the access cycle in which pready rose.
    task automatic xfer(input bit b0, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic er, output int lat);
        logic rdy;
        if (b0) begin
            psel0 = 1'b1; penable0 = 1'b0; pwrite0 = wr; paddr0 = a; pwdata0 = d;
        end else begin
            psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        end
`ifdef APB_SLAVE_PSTRB_EN
        if (b0) pstrb0 = s; else pstrb = s;
`endif
        @(posedge pclk); #1;
        if (b0) penable0 = 1'b1; else penable = 1'b1;
        lat = 1;
        rdy = b0 ? pready0 : pready;
        while (!rdy && lat < 10) begin
            @(posedge pclk); #1;
            lat++;
            rdy = b0 ? pready0 : pready;
        end
        rd = b0 ? prdata0 : prdata;
        er = b0 ? pslverr0 : pslverr;
        @(posedge pclk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          c0;

        rst = 1'b1; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
        pwrite0 = 1'b0; paddr0 = 32'h0; pwdata0 = 32'h0;
`ifdef APB_SLAVE_PSTRB_EN
        pstrb = 4'b0000; pstrb0 = 4'b0000;
`endif
        bus_idle();
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_pready", {31'd0, pready}, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("rst_prdata", prdata, 32'h0);
        rst = 1'b0;
        @(posedge pclk); #1;

        // Write then read at 0x10 with two wait states.
        xfer(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        chk("wr10_lat", 32'(lat), 32'd3);
        chk("wr10_err", {31'd0, er}, 32'd0);
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("rd10_lat", 32'(lat), 32'd3);
        chk("rd10_data", rd, 32'hDEAD_BEEF);
        chk("rd10_err", {31'd0, er}, 32'd0);
        chk("post_pready", {31'd0, pready}, 32'd0);
        chk("post_prdata", prdata, 32'h0);
        bus_idle();
        @(posedge pclk); #1;

        // Out-of-window write must not alias onto any word.
        xfer(1'b0, 1'b1, 32'h3FC, 32'h1357_9BDF, 4'hF, rd, er, lat);
        chk("wr3fc_err", {31'd0, er}, 32'd0);
        xfer(1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        chk("wr400_err", {31'd0, er}, 32'd1);
        chk("wr400_lat", 32'(lat), 32'd3);
        xfer(1'b0, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
        chk("rd3fc_data", rd, 32'h1357_9BDF);
        xfer(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        chk("rd0_data", rd, 32'h0);
        xfer(1'b0, 1'b0, 32'h402, 32'h0, 4'h0, rd, er, lat);
        chk("rd402_err", {31'd0, er}, 32'd1);
        chk("rd402_data", rd, 32'h0);
        bus_idle();
        @(posedge pclk); #1;

        // Reset during the first wait cycle of a write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hAAAA_5555;
        @(posedge pclk); #1;
        penable = 1'b1; rst = 1'b1;
        @(posedge pclk); #1;
        rst = 1'b0; bus_idle();
        for (int i = 0; i < 4; i++) begin
            chk("rstmid_pready", {31'd0, pready}, 32'd0);
            @(posedge pclk); #1;
        end
        xfer(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk("rd20_data", rd, 32'h0);
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("rd10_cleared", rd, 32'h0);
        bus_idle();
        @(posedge pclk); #1;

        // psel dropped in the last wait cycle aborts the write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h5A5A_5A5A;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        bus_idle();
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            chk("abort_pready", {31'd0, pready}, 32'd0);
        end
        xfer(1'b0, 1'b0, 32'h24, 32'h0, 4'h0, rd, er, lat);
        chk("rd24_data", rd, 32'h0);
        bus_idle();
        @(posedge pclk); #1;

        // Zero wait states, six back-to-back transfers.
        c0 = cyc;
        xfer(1'b1, 1'b1, 32'h0, 32'h1, 4'hF, rd, er, lat);
        chk("z_wr0_lat", 32'(lat), 32'd1);
        xfer(1'b1, 1'b1, 32'h4, 32'h2, 4'hF, rd, er, lat);
        chk("z_wr4_lat", 32'(lat), 32'd1);
        xfer(1'b1, 1'b1, 32'h8, 32'h3, 4'hF, rd, er, lat);
        chk("z_wr8_lat", 32'(lat), 32'd1);
        xfer(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
        chk("z_rd8_data", rd, 32'h3);
        chk("z_rd8_lat", 32'(lat), 32'd1);
        xfer(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
        chk("z_rd4_data", rd, 32'h2);
        xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        chk("z_rd0_data", rd, 32'h1);
        chk("z_rd0_err", {31'd0, er}, 32'd0);
        chk("z_cycles", 32'(cyc - c0), 32'd12);
        bus_idle();
        @(posedge pclk); #1;

`ifdef APB_SLAVE_PSTRB_EN
        // Byte strobes: partial write, strobed read error, empty-strobe write.
        xfer(1'b0, 1'b1, 32'h30, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        xfer(1'b0, 1'b1, 32'h30, 32'h1234_5678, 4'b0101, rd, er, lat);
        chk("strb_wr_err", {31'd0, er}, 32'd0);
        xfer(1'b0, 1'b0, 32'h30, 32'h0, 4'b0000, rd, er, lat);
        chk("strb_rd_data", rd, 32'hFF34_FF78);
        xfer(1'b0, 1'b0, 32'h30, 32'h0, 4'b0001, rd, er, lat);
        chk("strb_rd_err", {31'd0, er}, 32'd1);
        chk("strb_rd_zero", rd, 32'h0);
        xfer(1'b0, 1'b1, 32'h30, 32'h0, 4'b0000, rd, er, lat);
        chk("strb0_err", {31'd0, er}, 32'd0);
        xfer(1'b0, 1'b0, 32'h30, 32'h0, 4'b0000, rd, er, lat);
        chk("strb0_data", rd, 32'hFF34_FF78);
        bus_idle();
        @(posedge pclk); #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
